// File: rtl/ad9643_spi_port.sv
// rtl/ad9643_spi_port.sv - SPI slave front-end decoding AD9643 serial frames into register-file accesses
module ad9643_spi_port #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        csb,
    input  logic        sdi,
    output logic        sdo,
    output logic        sdo_oe,
    output logic        reg_write,
    output logic [12:0] reg_addr,
    output logic [7:0]  reg_wrdata,
    input  logic [7:0]  reg_rddata,
    output logic        txn_done
);
    typedef enum logic [2:0] {IDLE, INSTR, WDATA, RDATA, HOLD} state_t;
    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, csb_sync, sdi_sync;
    logic        sclk_d, csb_d;
    logic        sclk_s, csb_s, sdi_s;
    logic        sclk_rise, sclk_fall, csb_rise, csb_fall;
    logic [14:0] shreg;
    logic [3:0]  bit_cnt;
    logic [1:0]  byte_cnt;
    logic        stream, byte_done, load_rd, byte_seen;
    logic        instr_last, byte_last, frame_last;

    // csb chain resets low so a reset taken with csb held low never fakes a frame start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync <= '0;
            csb_sync  <= '0;
            sdi_sync  <= '0;
            sclk_d    <= 1'b0;
            csb_d     <= 1'b0;
        end else begin
            sclk_sync[0] <= sclk;
            csb_sync[0]  <= csb;
            sdi_sync[0]  <= sdi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_sync[i] <= sclk_sync[i-1];
                csb_sync[i]  <= csb_sync[i-1];
                sdi_sync[i]  <= sdi_sync[i-1];
            end
            sclk_d <= sclk_s;
            csb_d  <= csb_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign csb_s     = csb_sync[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d & ~csb_s;
    assign sclk_fall = ~sclk_s & sclk_d & ~csb_s;
    assign csb_rise  = csb_s & ~csb_d;
    assign csb_fall  = ~csb_s & csb_d;

    assign instr_last = sclk_rise && (state == INSTR) && (bit_cnt == 4'd15);
    assign byte_last  = sclk_rise && ((state == WDATA) || (state == RDATA)) && (bit_cnt == 4'd7);
    assign frame_last = byte_last && !stream && (byte_cnt == 2'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (csb_rise) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:         if (csb_fall)   state_nxt = INSTR;
                INSTR:        if (instr_last) state_nxt = shreg[14] ? RDATA : WDATA;
                WDATA, RDATA: if (frame_last) state_nxt = HOLD;
                default:      state_nxt = state;
            endcase
        end
    end

    always_comb begin
        sdo_oe = (state == RDATA);
        sdo    = sdo_oe & shreg[7];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            stream     <= 1'b0;
            byte_done  <= 1'b0;
            load_rd    <= 1'b0;
            byte_seen  <= 1'b0;
            reg_write  <= 1'b0;
            reg_addr   <= '0;
            reg_wrdata <= '0;
            txn_done   <= 1'b0;
        end else begin
            reg_write <= 1'b0;
            byte_done <= 1'b0;
            load_rd   <= 1'b0;
            txn_done  <= csb_rise & byte_seen;
            if (csb_rise || csb_fall) byte_seen <= 1'b0;

            // an sclk rise landing with the csb fall is already bit 0 of the frame
            if (state == IDLE && csb_fall) begin
                bit_cnt <= sclk_rise ? 4'd1 : 4'd0;
                if (sclk_rise) shreg <= {shreg[13:0], sdi_s};
            end

            if (state == INSTR && sclk_rise) begin
                shreg   <= {shreg[13:0], sdi_s};
                bit_cnt <= bit_cnt + 4'd1;
                if (instr_last) begin
                    bit_cnt  <= 4'd0;
                    reg_addr <= {shreg[11:0], sdi_s};
                    byte_cnt <= shreg[13:12] + 2'd1;
                    stream   <= &shreg[13:12];
                    load_rd  <= shreg[14];
                end
            end

            if ((state == WDATA || state == RDATA) && sclk_rise) begin
                bit_cnt <= byte_last ? 4'd0 : bit_cnt + 4'd1;
                if (state == WDATA) shreg <= {shreg[13:0], sdi_s};
                if (byte_last) begin
                    byte_done <= 1'b1;
                    byte_seen <= 1'b1;
                    if (state == WDATA) begin
                        reg_wrdata <= {shreg[6:0], sdi_s};
                        reg_write  <= 1'b1;
                    end
                end
            end

            // the fall that precedes each byte's first sampling rise keeps the freshly loaded MSB
            if (state == RDATA && sclk_fall && bit_cnt != 4'd0)
                shreg[7:0] <= {shreg[6:0], 1'b0};

            if (load_rd) shreg[7:0] <= reg_rddata;

            if (byte_done) begin
                reg_addr <= reg_addr - 13'd1;
                byte_cnt <= byte_cnt - 2'd1;
                if (state == RDATA) load_rd <= 1'b1;
            end
        end
    end
endmodule
